// File: rtl/jzjpcc_mmio_bank.sv
// MMIO window on the data bus: eight synchronized input words, eight byte-writable
// output words and a sticky W1C change-status register, with one-cycle registered reads.
module jzjpcc_mmio_bank #(
   parameter logic [29:0] BASE_ADDRESS = 30'h3FFF_FFE0
) (
   input  logic        clock,
   input  logic        not_reset,
   input  logic [29:0] address,
   input  logic        readEnable,
   input  logic        writeEnable,
   input  logic [3:0]  byteWriteMask,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        readValid,
   output logic        hit,
   input  logic [31:0] mmioInputs [8],
   output logic [31:0] mmioOutputs [8]
);

   logic [4:0]  off;
   logic        rd_hit;
   logic        wr_hit;
   logic [31:0] byte_mask;
   logic [31:0] read_mux;
   logic [31:0] sync1 [8];
   logic [31:0] sync2 [8];
   logic [31:0] prev [8];
   logic [7:0]  status;
   logic [7:0]  flag_set;
   logic [7:0]  flag_clr;
   logic [1:0]  warm;

   // The window is 32-word aligned, so the upper address bits alone select it.
   assign hit       = (address[29:5] == BASE_ADDRESS[29:5]);
   assign off       = address[4:0];
   assign rd_hit    = hit & readEnable;
   assign wr_hit    = hit & writeEnable;
   assign byte_mask = {{8{byteWriteMask[3]}}, {8{byteWriteMask[2]}},
                       {8{byteWriteMask[1]}}, {8{byteWriteMask[0]}}};

   always_comb begin
      read_mux = '0;
      case (off[4:3])
         2'b00:   read_mux = sync2[off[2:0]];
         2'b01:   read_mux = mmioOutputs[off[2:0]];
         default: if (off == 5'd16) read_mux = {24'h0, status};
      endcase
   end

   always_comb begin
      flag_set = '0;
      flag_clr = '0;
      for (int i = 0; i < 8; i++)
         flag_set[i] = (warm == 2'd3) && (sync2[i] != prev[i]);
      if (wr_hit && (off == 5'd16) && byteWriteMask[0])
         flag_clr = writeData[7:0];
   end

   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset) begin
         for (int i = 0; i < 8; i++) begin
            sync1[i] <= '0;
            sync2[i] <= '0;
            prev[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            sync1[i] <= mmioInputs[i];
            sync2[i] <= sync1[i];
            prev[i]  <= sync2[i];
         end
      end
   end

   // Detection stays off until the synchronizer chain holds post-reset samples.
   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset)
         warm <= 2'd0;
      else if (warm != 2'd3)
         warm <= warm + 2'd1;
   end

   // A set on the same edge as a clear wins.
   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset)
         status <= '0;
      else
         status <= (status & ~flag_clr) | flag_set;
   end

   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset) begin
         for (int i = 0; i < 8; i++)
            mmioOutputs[i] <= '0;
      end else if (wr_hit && (off[4:3] == 2'b01)) begin
         mmioOutputs[off[2:0]] <= (mmioOutputs[off[2:0]] & ~byte_mask) |
                                  (writeData & byte_mask);
      end
   end

   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset) begin
         readData  <= '0;
         readValid <= 1'b0;
      end else begin
         readValid <= rd_hit;
         if (rd_hit)
            readData <= read_mux;
      end
   end

endmodule

// File: tb/tb_jzjpcc_mmio_bank.sv
// Randomized bench for jzjpcc_mmio_bank against a snapshot-history reference model,
// plus directed checks of the address map, W1C, warm-up and reset behaviour.
module tb_jzjpcc_mmio_bank;

   localparam logic [29:0] BASE = 30'h3FFF_FFE0;

   logic        clock = 1'b0;
   logic        not_reset = 1'b0;
   logic [29:0] address = BASE;
   logic        readEnable = 1'b0;
   logic        writeEnable = 1'b0;
   logic [3:0]  byteWriteMask = 4'h0;
   logic [31:0] writeData = 32'h0;
   logic [31:0] readData;
   logic        readValid;
   logic        hit;
   logic [31:0] mmio_in [8];
   logic [31:0] mmio_out [8];

   jzjpcc_mmio_bank #(.BASE_ADDRESS(BASE)) dut (
      .clock(clock),
      .not_reset(not_reset),
      .address(address),
      .readEnable(readEnable),
      .writeEnable(writeEnable),
      .byteWriteMask(byteWriteMask),
      .writeData(writeData),
      .readData(readData),
      .readValid(readValid),
      .hit(hit),
      .mmioInputs(mmio_in),
      .mmioOutputs(mmio_out)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: input samples per edge (newest first) and the architectural registers.
   logic [255:0] hist [$];
   logic [31:0]  exp_out [8];
   logic [7:0]   exp_status;
   logic [31:0]  exp_rd;
   logic         exp_rv;
   int           edges;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] seen_word(input int age, input int i);
      logic [255:0] s;
      if (age >= hist.size()) return 32'h0;
      s = hist[age];
      return s[i*32 +: 32];
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < 8; i++) exp_out[i] = 32'h0;
      exp_status = 8'h0;
      exp_rd = 32'h0;
      exp_rv = 1'b0;
      edges = 0;
   endtask

   task automatic check_outputs();
      chk("readValid", {31'h0, readValid}, {31'h0, exp_rv});
      chk("readData", readData, exp_rd);
      for (int i = 0; i < 8; i++) chk($sformatf("out%0d", i), mmio_out[i], exp_out[i]);
   endtask

   // One clock edge: predict from the spec rules, advance, then compare.
   task automatic step();
      logic [29:0]  d;
      bit           in_win;
      int           o;
      logic [31:0]  rdv;
      logic [7:0]   setf;
      logic [7:0]   clr;
      logic [255:0] snap;
      d = address - BASE;
      in_win = (d < 30'd32);
      o = int'(d[4:0]);
      chk("hit", {31'h0, hit}, {31'h0, in_win});
      rdv = 32'h0;
      if (o < 8) rdv = seen_word(1, o);
      else if (o < 16) rdv = exp_out[o-8];
      else if (o == 16) rdv = {24'h0, exp_status};
      setf = 8'h0;
      if (edges >= 3)
         for (int i = 0; i < 8; i++) setf[i] = (seen_word(1, i) != seen_word(2, i));
      clr = 8'h0;
      if (in_win && writeEnable) begin
         if (o >= 8 && o < 16)
            for (int b = 0; b < 4; b++)
               if (byteWriteMask[b]) exp_out[o-8][8*b +: 8] = writeData[8*b +: 8];
         if (o == 16 && byteWriteMask[0]) clr = writeData[7:0];
      end
      exp_status = (exp_status & ~clr) | setf;
      if (in_win && readEnable) begin
         exp_rd = rdv;
         exp_rv = 1'b1;
      end else begin
         exp_rv = 1'b0;
      end
      for (int i = 0; i < 8; i++) snap[i*32 +: 32] = mmio_in[i];
      hist.push_front(snap);
      if (hist.size() > 4) void'(hist.pop_back());
      edges++;
      @(posedge clock);
      #1;
      check_outputs();
   endtask

   task automatic bus(input logic [29:0] a, input bit re, input bit we,
                      input logic [3:0] m, input logic [31:0] wd);
      address = a;
      readEnable = re;
      writeEnable = we;
      byteWriteMask = m;
      writeData = wd;
      step();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) bus(BASE + 30'd24, 1'b0, 1'b0, 4'h0, 32'h0);
   endtask

   task automatic rd(input int o);
      bus(BASE + 30'(o), 1'b1, 1'b0, 4'h0, 32'h0);
   endtask

   task automatic wr(input int o, input logic [3:0] m, input logic [31:0] wd);
      bus(BASE + 30'(o), 1'b0, 1'b1, m, wd);
   endtask

   // Asserted and released 1 time unit after an edge; outputs must clear without a clock.
   task automatic do_reset();
      not_reset = 1'b0;
      #2;
      model_reset();
      check_outputs();
      @(posedge clock);
      #1;
      not_reset = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mmio_in[i] = 32'h0;
      model_reset();
      // Inputs nonzero across reset release: warm-up must keep STATUS clear.
      for (int i = 0; i < 8; i++) mmio_in[i] = 32'hA5A5_0000 | 32'(i);
      #1;
      do_reset();
      for (int k = 0; k < 6; k++) rd(16);
      chk("warmup_status", readData, 32'h0);

      // Reset mid-operation with a read in flight.
      wr(11, 4'hF, 32'hDEAD_BEEF);
      chk("out3_set", mmio_out[3], 32'hDEAD_BEEF);
      address = BASE + 30'd11;
      readEnable = 1'b1;
      do_reset();
      idle(1);
      chk("rv_after_reset", {31'h0, readValid}, 32'h0);
      rd(11);
      chk("rd_off11", readData, 32'h0);
      chk("rv_off11", {31'h0, readValid}, 32'h1);

      // Byte-masked writes.
      wr(10, 4'b0101, 32'hAABB_CCDD);
      wr(9, 4'b1111, 32'h1122_3344);
      chk("out2_mask", mmio_out[2], 32'h00BB_00DD);
      chk("out1_full", mmio_out[1], 32'h1122_3344);
      rd(10);
      chk("rd_off10", readData, 32'h00BB_00DD);

      // Input synchronizer latency and read-only input words.
      idle(4);
      mmio_in[0] = 32'h1234_5678;
      rd(0);
      rd(0);
      rd(0);
      chk("in0_visible", readData, 32'h1234_5678);
      wr(0, 4'hF, 32'hFFFF_FFFF);
      rd(0);
      chk("in0_ro", readData, 32'h1234_5678);

      // Change flag and W1C.
      idle(4);
      wr(16, 4'h1, 32'hFF);
      mmio_in[5] = mmio_in[5] ^ 32'h1;
      idle(3);
      rd(16);
      chk("status_set", readData, 32'h20);
      wr(16, 4'b0001, 32'h20);
      rd(16);
      chk("status_clr", readData, 32'h0);
      mmio_in[5] = mmio_in[5] ^ 32'h1;
      idle(3);
      wr(16, 4'b0010, 32'h20);
      rd(16);
      chk("status_nomask", readData, 32'h20);
      wr(16, 4'b0001, 32'h20);
      mmio_in[5] = mmio_in[5] ^ 32'h1;
      idle(2);
      wr(16, 4'b0001, 32'h20);
      rd(16);
      chk("status_set_wins", readData, 32'h20);

      // Out-of-window, unmapped offset, same-cycle read/write.
      bus(BASE + 30'd40, 1'b1, 1'b1, 4'hF, 32'h5555_5555);
      chk("oow_rv", {31'h0, readValid}, 32'h0);
      rd(20);
      chk("off20_rd", readData, 32'h0);
      chk("off20_rv", {31'h0, readValid}, 32'h1);
      wr(8, 4'hF, 32'hCAFE_0001);
      bus(BASE + 30'd8, 1'b1, 1'b1, 4'hF, 32'hBEEF_0002);
      chk("rw_old", readData, 32'hCAFE_0001);
      chk("rw_new", mmio_out[0], 32'hBEEF_0002);

      // Randomized traffic.
      for (int k = 0; k < 800; k++) begin
         logic [29:0] a;
         if ($urandom_range(0, 3) == 0) mmio_in[$urandom_range(0, 7)] = $urandom;
         if ($urandom_range(0, 9) == 0) a = 30'($urandom);
         else a = BASE + 30'($urandom_range(0, 31));
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            bus(a, 1'($urandom), 1'($urandom), 4'($urandom), $urandom);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/jzjpcc_mmio_bank.md
# jzjpcc_mmio_bank

Memory-mapped responder that exposes the core's eight MMIO input words and eight MMIO output words on the data-memory bus. The core's load/store unit is the initiator. This block decodes word addresses inside its window, returns registered read data, applies byte-masked writes to the output registers, and keeps a sticky change-status register for the inputs. It sits between the core's data-bus port and the top-level `mmioInputs`/`mmioOutputs` arrays.

## Interface
Parameters:
- `BASE_ADDRESS`, default 30'h3FFF_FFE0: word address of the window base. Bits [4:0] must be 0; the window is 32 words.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `not_reset`  in  1  reset, asynchronous, active-low.
- `address`  in  30  word address, byte address bits [31:2].
- `readEnable`  in  1  read request this cycle.
- `writeEnable`  in  1  write request this cycle.
- `byteWriteMask`  in  4  bit n enables byte n (`writeData[8n+7:8n]`).
- `writeData`  in  32  store data.
- `readData`  out  32  registered load data.
- `readValid`  out  1  `readData` holds the response to a hit read issued in the previous cycle.
- `hit`  out  1  combinational: `address` is inside the window.
- `mmioInputs`  in  8×32  asynchronous external inputs.
- `mmioOutputs`  out  8×32  output registers.

## Operation
Word offset is `off = address - BASE_ADDRESS`, valid when `hit`.

Address map:
- **off 0–7, input registers (read-only).** Reads return synchronized `mmioInputs[off]`. Writes are ignored.
- **off 8–15, output registers (read/write).** Register index is `off-8`. Reads return the current register value. Writes update only the bytes enabled in `byteWriteMask`.
- **off 16, STATUS.** Bits [7:0] are sticky change flags, one per input word. Bits [31:8] read 0. A write clears each flag whose `writeData` bit is 1, but only if byte 0 is enabled in `byteWriteMask` (write-1-to-clear).
- **off 17–31.** Reads return 0. Writes are ignored.
- **Outside the window.** `hit`=0. No state changes. `readValid` is 0 next cycle.

Input synchronizers and change detection:
- Each input word passes through two flops (`sync1`, `sync2`), then into `prev`.
- Flag i sets on any edge where `sync2[i] != prev[i]` and detection is enabled.
- A 2-bit warm-up counter resets to 0 and saturates at 3. Detection is enabled only when the counter is 3, so no flags set on the first three edges after reset release.

Simultaneous events:
- **Read and write to the same register in one cycle:** the read returns the old value; the write lands at the same edge.
- **Flag set and W1C clear on the same bit and edge:** set wins, so the flag is 1 afterwards.
- **`readEnable` and `writeEnable` both high:** both are performed.

## Timing
- **Read latency:** 1 cycle. A request with `hit` at edge k produces `readData`/`readValid` valid after edge k.
- **`readData` hold:** it keeps its last value when no hit read is issued. `readValid` is high for exactly one cycle per hit read.
- **Write latency:** `mmioOutputs` reflects a write after the edge on which `writeEnable`&`hit` was sampled.
- **Input-to-readable latency:** an input change set up before edge k appears in `sync2` after edge k+1. A read issued in the cycle after edge k+1 returns it. The change flag sets at edge k+2.
- **Reset values (asynchronous, immediate on `not_reset`=0):**
  - `mmioOutputs` all 0, `readData` 0, `readValid` 0.
  - STATUS 0, `sync1`/`sync2`/`prev` 0, warm-up counter 0.
- **Reset mid-operation:** an in-flight read's response is discarded (`readValid` 0 after release). Pending writes are lost.
- `hit` is purely combinational from `address` and has no reset dependence.

## Test plan
- **Reset/defaults:** hold `not_reset`=0 mid-run with `mmioOutputs[3]`=32'hDEADBEEF → all outputs 0 immediately. After release, a read of off 11 returns 0 with `readValid`=1 one cycle later.
- **Byte-masked write:** write 32'hAABBCCDD mask 4'b0101 to off 10, then mask 4'b1111 value 32'h11223344 to off 9 → `mmioOutputs[2]`=32'h00BB00DD, `mmioOutputs[1]`=32'h11223344. Reading off 10 returns 32'h00BB00DD.
- **Input sync and read:** `mmioInputs[0]`=32'h12345678 held steady → a read of off 0 returns 32'h12345678 no earlier than the read issued after the second edge. A write of 32'hFFFFFFFF to off 0 has no effect.
- **Change flag / W1C:** after warm-up, toggle `mmioInputs[5]` → STATUS reads 32'h20.
  - Write 32'h20 mask 4'b0001 → STATUS reads 0.
  - Write 32'h20 mask 4'b0010 → flag unchanged.
  - Toggle the input again on the same edge as a W1C → flag remains 1.
- **Warm-up suppression:** inputs nonzero before and during reset release → STATUS stays 0 through and after the first three edges.
- **Out-of-window / unmapped:** address `BASE_ADDRESS`+40, read and write → `hit`=0, `readValid`=0, no output change. Off 20 read → `readData`=0, `readValid`=1. Same-cycle read/write to off 8 → read returns the pre-write value.
